// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM read arbiter.
//   id_width() : requester-id width for a given requester count (min 1 bit)
//   bypass_t   : {id, tag} word carried alongside a read through the RAM
//                pipeline, sized for the default 4-requester / 4-bit-tag build
package ram_arb_pkg;

  localparam int ARB_REQ_CNT   = 4;
  localparam int ARB_TAG_WIDTH = 4;

  function automatic int id_width(input int req_cnt);
    return (req_cnt > 1) ? $clog2(req_cnt) : 1;
  endfunction

  localparam int ARB_ID_WIDTH = id_width(ARB_REQ_CNT);

  typedef struct packed {
    logic [ARB_ID_WIDTH-1:0]  id;
    logic [ARB_TAG_WIDTH-1:0] tag;
  } bypass_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk_i, rst_i : clock, synchronous active-high reset (grant forced low)
//   req          : request vector
//   gnt          : one-hot grant (or zero), combinational from req
//   gnt_id       : index of the granted requester (valid when |gnt)
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int REQ_CNT  = 4,
  parameter int ID_WIDTH = id_width(REQ_CNT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [REQ_CNT-1:0]  req,
  output logic [REQ_CNT-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_id
);

  logic [ID_WIDTH-1:0] ptr;
  int                  idx;

  // Scan offsets from high to low so the last hit is the nearest requester
  // at or after ptr (wrap-around).
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    if (!rst_i) begin
      for (int i = REQ_CNT - 1; i >= 0; i--) begin
        idx = int'(ptr) + i;
        if (idx >= REQ_CNT) idx = idx - REQ_CNT;
        if (req[ID_WIDTH'(idx)]) gnt_id = ID_WIDTH'(idx);
      end
      if (|req) gnt[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ptr <= '0;
    else if (|gnt)
      ptr <= (int'(gnt_id) == REQ_CNT - 1) ? '0 : gnt_id + ID_WIDTH'(1);
  end

endmodule

// File: rtl/ram_read_arbiter.sv
// Shares the read port of one lookup RAM among REQ_CNT tagged requesters.
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   req_valid_i/addr_i/tag_i         : per-requester read request (flat vectors)
//   req_ready_o                      : combinational one-hot grant
//   wr_data_i/addr_i/enable_i        : table-update write stream
//   ram_wr_data_o/addr_o/enable_o    : registered RAM write port
//   ram_rd_addr_o/bypass_o/valid_o   : registered RAM read issue, bypass={id,tag}
//   ram_rd_data_i/bypass_i/valid_i   : RAM read return (1- or 2-cycle pipeline)
//   rsp_valid_o/data_o/tag_o         : registered response, valid one-hot by id
module ram_read_arbiter
  import ram_arb_pkg::*;
#(
  parameter int REQ_CNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int TAG_WIDTH  = 4,
  parameter int ID_WIDTH   = id_width(REQ_CNT)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [REQ_CNT-1:0]              req_valid_i,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [REQ_CNT*TAG_WIDTH-1:0]    req_tag_i,
  output logic [REQ_CNT-1:0]              req_ready_o,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic [ADDR_WIDTH-1:0]           wr_addr_i,
  input  logic                            wr_enable_i,
  output logic [DATA_WIDTH-1:0]           ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0]           ram_wr_addr_o,
  output logic                            ram_wr_enable_o,
  output logic [ADDR_WIDTH-1:0]           ram_rd_addr_o,
  output logic [ID_WIDTH+TAG_WIDTH-1:0]   ram_bypass_o,
  output logic                            ram_valid_o,
  input  logic [DATA_WIDTH-1:0]           ram_rd_data_i,
  input  logic [ID_WIDTH+TAG_WIDTH-1:0]   ram_bypass_i,
  input  logic                            ram_valid_i,
  output logic [REQ_CNT-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_data_o,
  output logic [TAG_WIDTH-1:0]            rsp_tag_o
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [TAG_WIDTH-1:0] tag;
  } bp_t;

  logic [ADDR_WIDTH-1:0] addr_arr [REQ_CNT];
  logic [TAG_WIDTH-1:0]  tag_arr  [REQ_CNT];
  logic [REQ_CNT-1:0]    hazard;
  logic [REQ_CNT-1:0]    cand;
  logic [REQ_CNT-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gnt_id;
  bp_t                   rtn;
  // Sticky flag for a returned id with no matching requester; probe-only.
  logic                  bad_id_seen_unused;

  // A read to the address being written this cycle waits one cycle so it
  // lands after the write and sees the new word.
  for (genvar g = 0; g < REQ_CNT; g++) begin : g_req
    assign addr_arr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign tag_arr[g]  = req_tag_i[g*TAG_WIDTH +: TAG_WIDTH];
    assign hazard[g]   = wr_enable_i && (addr_arr[g] == wr_addr_i);
  end

  assign cand        = req_valid_i & ~hazard;
  assign req_ready_o = gnt;

  rr_arbiter #(
    .REQ_CNT  (REQ_CNT),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req    (cand),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Write forwarding and read issue share the same register stage, so a
  // write and a read granted in one cycle reach the RAM together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_wr_data_o   <= '0;
      ram_wr_addr_o   <= '0;
      ram_wr_enable_o <= 1'b0;
      ram_valid_o     <= 1'b0;
      ram_rd_addr_o   <= '0;
      ram_bypass_o    <= '0;
    end else begin
      ram_wr_data_o   <= wr_data_i;
      ram_wr_addr_o   <= wr_addr_i;
      ram_wr_enable_o <= wr_enable_i;
      ram_valid_o     <= |gnt;
      if (|gnt) begin
        ram_rd_addr_o <= addr_arr[gnt_id];
        ram_bypass_o  <= {gnt_id, tag_arr[gnt_id]};
      end
    end
  end

  assign rtn = bp_t'(ram_bypass_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o        <= '0;
      rsp_data_o         <= '0;
      rsp_tag_o          <= '0;
      bad_id_seen_unused <= 1'b0;
    end else begin
      for (int i = 0; i < REQ_CNT; i++)
        rsp_valid_o[i] <= ram_valid_i && (rtn.id == ID_WIDTH'(i));
      if (ram_valid_i) begin
        rsp_data_o <= ram_rd_data_i;
        rsp_tag_o  <= rtn.tag;
        if (int'(rtn.id) >= REQ_CNT) bad_id_seen_unused <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed bench for ram_read_arbiter with a behavioural RAM (latency 1 or 2,
// read-before-write, contents re-initialised on reset).
module tb_ram_read_arbiter;
  import ram_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int TW = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*AW-1:0]  req_addr;
  logic [N*TW-1:0]  req_tag;
  logic [N-1:0]     req_ready;
  logic [DW-1:0]    wr_data;
  logic [AW-1:0]    wr_addr;
  logic             wr_enable;
  logic [DW-1:0]    ram_wr_data;
  logic [AW-1:0]    ram_wr_addr;
  logic             ram_wr_enable;
  logic [AW-1:0]    ram_rd_addr;
  logic [IW+TW-1:0] ram_bypass;
  logic             ram_valid;
  logic [DW-1:0]    ram_rd_data_in;
  logic [IW+TW-1:0] ram_bypass_in;
  logic             ram_valid_in;
  logic [N-1:0]     rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [TW-1:0]    rsp_tag;

  int nvec = 0;
  int nerr = 0;
  int lat  = 1;

  ram_read_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .req_tag_i       (req_tag),
    .req_ready_o     (req_ready),
    .wr_data_i       (wr_data),
    .wr_addr_i       (wr_addr),
    .wr_enable_i     (wr_enable),
    .ram_wr_data_o   (ram_wr_data),
    .ram_wr_addr_o   (ram_wr_addr),
    .ram_wr_enable_o (ram_wr_enable),
    .ram_rd_addr_o   (ram_rd_addr),
    .ram_bypass_o    (ram_bypass),
    .ram_valid_o     (ram_valid),
    .ram_rd_data_i   (ram_rd_data_in),
    .ram_bypass_i    (ram_bypass_in),
    .ram_valid_i     (ram_valid_in),
    .rsp_valid_o     (rsp_valid),
    .rsp_data_o      (rsp_data),
    .rsp_tag_o       (rsp_tag)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: mem[a] = a ^ 0xA5 after reset.
  logic [DW-1:0]    mem [64];
  logic             v1, v2;
  logic [DW-1:0]    d1, d2;
  logic [IW+TW-1:0] b1, b2;

  always @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int i = 0; i < 64; i++) mem[i] <= DW'(i) ^ 8'hA5;
    end else begin
      v1 <= ram_valid;
      v2 <= v1;
      if (ram_wr_enable) mem[ram_wr_addr] <= ram_wr_data;
    end
    d1 <= mem[ram_rd_addr];
    d2 <= d1;
    b1 <= ram_bypass;
    b2 <= b1;
  end

  assign ram_valid_in   = (lat == 2) ? v2 : v1;
  assign ram_rd_data_in = (lat == 2) ? d2 : d1;
  assign ram_bypass_in  = (lat == 2) ? b2 : b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
    req_addr[i*AW +: AW] = a;
    req_tag[i*TW +: TW]  = t;
  endtask

  // Stream with L=2 and interleaved writes (cycle E0..E9).
  logic          e_wen [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [AW-1:0] e_wa  [10] = '{6'h22, 6'h30, 6'h00, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  logic [DW-1:0] e_wd  [10] = '{8'h77, 8'h11, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [N-1:0]  e_rdy [10] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [N-1:0]  e_rv  [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                                4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
  logic [DW-1:0] e_rd  [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h84, 8'h77, 8'h86, 8'h00, 8'h99, 8'h00};
  logic [TW-1:0] e_rt  [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'hA, 4'hB, 4'h0, 4'h8, 4'h0};

  bypass_t      bp_exp;
  logic [N-1:0] hs;

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_tag = '0;
    wr_data = '0; wr_addr = '0; wr_enable = 1'b0;

    // Reset: no grant even with requests pending, outputs at reset values.
    @(negedge clk); req_valid = '1;
    #1 chk("rst_ready", req_ready, 0);
    @(negedge clk);
    chk("rst_ram_valid", ram_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wr_en", ram_wr_enable, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    chk("rst_bypass", ram_bypass, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    rst = 1'b0; req_valid = '0;

    // A: single request, L=1.
    @(negedge clk);
    set_req(2, 6'h15, 4'h9); req_valid = 4'b0100;
    #1 chk("A_ready", req_ready, 4'b0100);
    @(negedge clk); req_valid = '0;
    bp_exp.id = 2'd2; bp_exp.tag = 4'h9;
    chk("A_issue_v", ram_valid, 1);
    chk("A_issue_addr", ram_rd_addr, 6'h15);
    chk("A_issue_bypass", ram_bypass, bp_exp);
    @(negedge clk);
    chk("A_rsp_early", rsp_valid, 0);
    @(negedge clk);
    chk("A_rsp_valid", rsp_valid, 4'b0100);
    chk("A_rsp_data", rsp_data, 8'hB0);
    chk("A_rsp_tag", rsp_tag, 4'h9);

    // B: all four requesting from reset -> 0,1,2,3,0,...
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), TW'(i));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("B_gnt%0d", k), req_ready, 32'd1 << (k % 4));
      @(negedge clk);
    end

    // C: requesters 1 and 3, with ptr moved to 2 first.
    req_valid = 4'b0010;
    #1 chk("C_pre", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'b1010;
    #1 chk("C_gnt0", req_ready, 4'b1000);
    @(negedge clk);
    #1 chk("C_gnt1", req_ready, 4'b0010);
    @(negedge clk);
    #1 chk("C_gnt2", req_ready, 4'b1000);
    @(negedge clk); req_valid = '0;

    // D: write hazard on requester 0 (ptr = 0).
    set_req(0, 6'h07, 4'h3); set_req(1, 6'h08, 4'h4); req_valid = 4'b0011;
    wr_enable = 1'b1; wr_addr = 6'h07; wr_data = 8'h5C;
    #1 chk("D_mask", req_ready, 4'b0010);
    @(negedge clk); wr_enable = 1'b0; req_valid = 4'b0001;
    #1 chk("D_next", req_ready, 4'b0001);
    chk("D_wr_en", ram_wr_enable, 1);
    chk("D_wr_addr", ram_wr_addr, 6'h07);
    chk("D_wr_data", ram_wr_data, 8'h5C);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    chk("D_rsp1_valid", rsp_valid, 4'b0010);
    chk("D_rsp1_data", rsp_data, 8'hAD);
    chk("D_rsp1_tag", rsp_tag, 4'h4);
    @(negedge clk);
    chk("D_rsp0_valid", rsp_valid, 4'b0001);
    chk("D_rsp0_data", rsp_data, 8'h5C);
    chk("D_rsp0_tag", rsp_tag, 4'h3);
    @(negedge clk); lat = 2;

    // E: L=2 back-to-back with interleaved writes (ptr = 1).
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, AW'(6'h20 + i), TW'(8 + i));
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      wr_enable = e_wen[k]; wr_addr = e_wa[k]; wr_data = e_wd[k];
      #1;
      chk($sformatf("E_ready%0d", k), req_ready, e_rdy[k]);
      chk($sformatf("E_rsp_valid%0d", k), rsp_valid, e_rv[k]);
      if (e_rv[k] != '0) begin
        chk($sformatf("E_rsp_data%0d", k), rsp_data, e_rd[k]);
        chk($sformatf("E_rsp_tag%0d", k), rsp_tag, e_rt[k]);
      end
      hs = req_ready;
      @(negedge clk);
      req_valid = req_valid & ~hs;
    end
    wr_enable = 1'b0;

    // F: reset for one cycle mid-stream (ptr = 1).
    req_valid = '1; wr_enable = 1'b1; wr_addr = 6'h31; wr_data = 8'h42;
    #1 chk("F_ready0", req_ready, 4'b0010);
    @(negedge clk); rst = 1'b1;
    #1 chk("F_ready_rst", req_ready, 0);
    @(negedge clk); rst = 1'b0; wr_enable = 1'b0;
    #1;
    chk("F_ram_valid", ram_valid, 0);
    chk("F_rd_addr", ram_rd_addr, 0);
    chk("F_bypass", ram_bypass, 0);
    chk("F_wr_en", ram_wr_enable, 0);
    chk("F_wr_addr", ram_wr_addr, 0);
    chk("F_wr_data", ram_wr_data, 0);
    chk("F_rsp_valid", rsp_valid, 0);
    chk("F_rsp_data", rsp_data, 0);
    chk("F_rsp_tag", rsp_tag, 0);
    chk("F_ptr0", req_ready, 4'b0001);
    @(negedge clk); req_valid = '0;
    for (int k = 3; k < 6; k++) begin
      chk($sformatf("F_drop%0d", k), rsp_valid, 0);
      @(negedge clk);
    end
    chk("F_rsp_valid_new", rsp_valid, 4'b0001);
    chk("F_rsp_data_new", rsp_data, 8'h85);
    chk("F_rsp_tag_new", rsp_tag, 4'h8);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
